// File: rtl/array_shift_controller_if.sv
// rtl/array_shift_controller_if.sv - command and heap-port bundle for the array-shift sequencer
//
// Purpose: groups the executor command/status signals and the single-port heap
// memory signals of array_shift_controller.
// Ports (modport slave = the sequencer):
//   in : start, op, base, length, index, value, mem_rdata
//   out: mem_addr, mem_we, mem_wdata, busy, done, error, new_length, removed
// modport master is the mirror image (executor plus heap memory side).
interface array_shift_controller_if #(
    parameter int MemoryElementWidth = 12,
    parameter int AddressWidth       = 12
);
    logic                          start;
    logic                          op;
    logic [AddressWidth-1:0]       base;
    logic [MemoryElementWidth-1:0] length;
    logic [MemoryElementWidth-1:0] index;
    logic [MemoryElementWidth-1:0] value;
    logic [AddressWidth-1:0]       mem_addr;
    logic                          mem_we;
    logic [MemoryElementWidth-1:0] mem_wdata;
    logic [MemoryElementWidth-1:0] mem_rdata;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [MemoryElementWidth-1:0] new_length;
    logic [MemoryElementWidth-1:0] removed;

    modport slave (
        input  start, op, base, length, index, value, mem_rdata,
        output mem_addr, mem_we, mem_wdata, busy, done, error, new_length, removed
    );

    modport master (
        output start, op, base, length, index, value, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, busy, done, error, new_length, removed
    );
endinterface

// File: rtl/array_shift_controller.sv
// rtl/array_shift_controller.sv - insert/delete shift sequencer for one heap array area
//
// Purpose: performs insert-at-index (shift up) and delete-at-index (shift down)
// on an array held in single-port heap memory, one element per read/write pair.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - array_shift_controller_if.slave: command inputs, status outputs,
//           heap memory port (read data valid the cycle after a read address)
module array_shift_controller #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int AddressWidth       = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    array_shift_controller_if.slave  bus
);
    localparam int MEW = MemoryElementWidth;
    localparam int AW  = AddressWidth;

    localparam logic [MEW-1:0] ONE_E  = MEW'(1);
    localparam logic [AW-1:0]  ONE_A  = AW'(1);
    localparam logic [MEW-1:0] N_AREA = MEW'(NArea);

    typedef enum logic [2:0] {
        IDLE, FETCH, TAKE, READ, WRITE, PUT, DONE
    } state_t;

    state_t         state_q, state_d;
    logic           op_q, op_d;
    logic [AW-1:0]  base_q, base_d;
    logic [MEW-1:0] length_q, length_d;
    logic [MEW-1:0] index_q, index_d;
    logic [MEW-1:0] value_q, value_d;
    logic [MEW-1:0] i_q, i_d;
    logic           error_q, error_d;
    logic [MEW-1:0] new_length_q, new_length_d;
    logic [MEW-1:0] removed_q, removed_d;

    logic [MEW-1:0] i_dec, i_inc, last_idx;
    logic [AW-1:0]  addr_i, addr_index;

    assign i_dec      = i_q - ONE_E;
    assign i_inc      = i_q + ONE_E;
    // Only reached for a legal delete, where length_q >= 1.
    assign last_idx   = length_q - ONE_E;
    assign addr_i     = base_q + AW'(i_q);
    assign addr_index = base_q + AW'(index_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            base_q       <= '0;
            length_q     <= '0;
            index_q      <= '0;
            value_q      <= '0;
            i_q          <= '0;
            error_q      <= 1'b0;
            new_length_q <= '0;
            removed_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            base_q       <= base_d;
            length_q     <= length_d;
            index_q      <= index_d;
            value_q      <= value_d;
            i_q          <= i_d;
            error_q      <= error_d;
            new_length_q <= new_length_d;
            removed_q    <= removed_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        base_d        = base_q;
        length_d      = length_q;
        index_d       = index_q;
        value_d       = value_q;
        i_d           = i_q;
        error_d       = error_q;
        new_length_d  = new_length_q;
        removed_d     = removed_q;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    base_d   = bus.base;
                    length_d = bus.length;
                    index_d  = bus.index;
                    value_d  = bus.value;
                    error_d  = 1'b0;
                    if (!bus.op) begin
                        if (bus.index <= bus.length && bus.length < N_AREA) begin
                            i_d          = bus.length;
                            new_length_d = bus.length + ONE_E;
                            state_d      = (bus.length > bus.index) ? READ : PUT;
                        end else begin
                            error_d      = 1'b1;
                            new_length_d = bus.length;
                            state_d      = DONE;
                        end
                    end else begin
                        if (bus.index < bus.length) begin
                            new_length_d = bus.length - ONE_E;
                            state_d      = FETCH;
                        end else begin
                            error_d      = 1'b1;
                            new_length_d = bus.length;
                            state_d      = DONE;
                        end
                    end
                end
            end
            FETCH: begin
                bus.mem_addr = addr_index;
                state_d      = TAKE;
            end
            TAKE: begin
                removed_d = bus.mem_rdata;
                i_d       = index_q;
                state_d   = (index_q < last_idx) ? READ : DONE;
            end
            READ: begin
                // Insert walks downward pulling from i-1; delete walks upward pulling from i+1.
                bus.mem_addr = op_q ? (addr_i + ONE_A) : (addr_i - ONE_A);
                state_d      = WRITE;
            end
            WRITE: begin
                bus.mem_addr  = addr_i;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.mem_rdata;
                if (!op_q) begin
                    i_d     = i_dec;
                    state_d = (i_dec > index_q) ? READ : PUT;
                end else begin
                    i_d     = i_inc;
                    state_d = (i_inc < last_idx) ? READ : DONE;
                end
            end
            PUT: begin
                bus.mem_addr  = addr_index;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = value_q;
                state_d       = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.error      = error_q;
    assign bus.new_length = new_length_q;
    assign bus.removed    = removed_q;
endmodule

// File: tb/tb_array_shift_controller.sv
// tb/tb_array_shift_controller.sv - directed self-checking bench for array_shift_controller
module tb_array_shift_controller;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    logic        tb_we;
    logic [11:0] tb_addr;
    logic [11:0] tb_data;
    logic [11:0] heap [0:4095];

    array_shift_controller_if #(.MemoryElementWidth(12), .AddressWidth(12)) bus ();

    array_shift_controller #(
        .MemoryElementWidth(12),
        .NArea(10),
        .AddressWidth(12)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_we) heap[bus.mem_addr] <= bus.mem_wdata;
        else if (tb_we) heap[tb_addr] <= tb_data;
        bus.mem_rdata <= heap[bus.mem_addr];
    end

    task automatic put(input logic [11:0] a, input logic [11:0] d);
        @(negedge clock);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clock);
        #1 tb_we = 1'b0;
    endtask

    task automatic run_cmd(input logic o, input logic [11:0] b, input logic [11:0] len,
                           input logic [11:0] idx, input logic [11:0] val,
                           output int done_cyc, output int we_cnt, output int busy_cnt);
        int cyc;
        @(negedge clock);
        bus.op = o; bus.base = b; bus.length = len; bus.index = idx; bus.value = val;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        done_cyc = 0; we_cnt = 0; busy_cnt = 0; cyc = 1;
        while (done_cyc == 0 && cyc < 100) begin
            if (bus.mem_we) we_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cyc = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.error, bus.mem_we});
        end
        checks++;
        if (bus.mem_addr !== 12'd0 || bus.mem_wdata !== 12'd0 || bus.new_length !== 12'd0 || bus.removed !== 12'd0) begin
            errors++;
            $display("FAIL reset_values: addr=%0d wdata=%0d nl=%0d rem=%0d want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.new_length, bus.removed);
        end
    endtask

    task automatic test_insert();
        int dc, wc, bc;
        put(12'd100, 12'd5); put(12'd101, 12'd6); put(12'd102, 12'd7); put(12'd103, 12'd0);
        run_cmd(1'b0, 12'd100, 12'd3, 12'd1, 12'd9, dc, wc, bc);
        checks++;
        if (dc !== 6) begin errors++; $display("FAIL insert_done_cycle: got %0d want 6", dc); end
        checks++;
        if (bc !== 6) begin errors++; $display("FAIL insert_busy_cycles: got %0d want 6", bc); end
        checks++;
        if (wc !== 3) begin errors++; $display("FAIL insert_writes: got %0d want 3", wc); end
        checks++;
        if (bus.new_length !== 12'd4 || bus.error !== 1'b0) begin
            errors++; $display("FAIL insert_status: nl=%0d err=%b want 4 0", bus.new_length, bus.error);
        end
        @(negedge clock);
        checks++;
        if (heap[100] !== 12'd5 || heap[101] !== 12'd9 || heap[102] !== 12'd6 || heap[103] !== 12'd7) begin
            errors++; $display("FAIL insert_heap: got %0d %0d %0d %0d want 5 9 6 7",
                               heap[100], heap[101], heap[102], heap[103]);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL insert_done_pulse: done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_delete();
        int dc, wc, bc;
        run_cmd(1'b1, 12'd100, 12'd4, 12'd0, 12'd0, dc, wc, bc);
        checks++;
        if (dc !== 9) begin errors++; $display("FAIL delete_done_cycle: got %0d want 9", dc); end
        checks++;
        if (wc !== 3) begin errors++; $display("FAIL delete_writes: got %0d want 3", wc); end
        checks++;
        if (bus.removed !== 12'd5 || bus.new_length !== 12'd3 || bus.error !== 1'b0) begin
            errors++; $display("FAIL delete_status: rem=%0d nl=%0d err=%b want 5 3 0",
                               bus.removed, bus.new_length, bus.error);
        end
        @(negedge clock);
        checks++;
        if (heap[100] !== 12'd9 || heap[101] !== 12'd6 || heap[102] !== 12'd7 || heap[103] !== 12'd7) begin
            errors++; $display("FAIL delete_heap: got %0d %0d %0d %0d want 9 6 7 7",
                               heap[100], heap[101], heap[102], heap[103]);
        end
    endtask

    task automatic test_insert_end();
        int dc, wc, bc;
        put(12'd200, 12'd1); put(12'd201, 12'd2); put(12'd202, 12'd0);
        run_cmd(1'b0, 12'd200, 12'd2, 12'd2, 12'd11, dc, wc, bc);
        checks++;
        if (dc !== 2 || wc !== 1) begin
            errors++; $display("FAIL insert_end_timing: cyc=%0d writes=%0d want 2 1", dc, wc);
        end
        @(negedge clock);
        checks++;
        if (heap[200] !== 12'd1 || heap[201] !== 12'd2 || heap[202] !== 12'd11 || bus.new_length !== 12'd3) begin
            errors++; $display("FAIL insert_end_result: heap=%0d %0d %0d nl=%0d want 1 2 11 3",
                               heap[200], heap[201], heap[202], bus.new_length);
        end
    endtask

    task automatic test_delete_last();
        int dc, wc, bc;
        put(12'd103, 12'd8);
        run_cmd(1'b1, 12'd100, 12'd4, 12'd3, 12'd0, dc, wc, bc);
        checks++;
        if (dc !== 3 || wc !== 0) begin
            errors++; $display("FAIL delete_last_timing: cyc=%0d writes=%0d want 3 0", dc, wc);
        end
        checks++;
        if (bus.removed !== 12'd8 || bus.new_length !== 12'd3 || bus.error !== 1'b0) begin
            errors++; $display("FAIL delete_last_status: rem=%0d nl=%0d err=%b want 8 3 0",
                               bus.removed, bus.new_length, bus.error);
        end
    endtask

    task automatic test_errors();
        int dc, wc, bc;
        run_cmd(1'b0, 12'd100, 12'd10, 12'd0, 12'd3, dc, wc, bc);
        checks++;
        if (dc !== 1 || wc !== 0 || bus.error !== 1'b1 || bus.new_length !== 12'd10) begin
            errors++; $display("FAIL err_insert_full: cyc=%0d writes=%0d err=%b nl=%0d want 1 0 1 10",
                               dc, wc, bus.error, bus.new_length);
        end
        run_cmd(1'b1, 12'd100, 12'd4, 12'd4, 12'd0, dc, wc, bc);
        checks++;
        if (dc !== 1 || wc !== 0 || bus.error !== 1'b1 || bus.new_length !== 12'd4) begin
            errors++; $display("FAIL err_delete_range: cyc=%0d writes=%0d err=%b nl=%0d want 1 0 1 4",
                               dc, wc, bus.error, bus.new_length);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (bus.error !== 1'b1) begin
            errors++; $display("FAIL err_held: got %b want 1", bus.error);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, dc, dcnt;
        put(12'd300, 12'd1); put(12'd301, 12'd2); put(12'd302, 12'd3); put(12'd303, 12'd0);
        @(negedge clock);
        bus.op = 1'b0; bus.base = 12'd300; bus.length = 12'd3; bus.index = 12'd1; bus.value = 12'd4;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        // Keep start asserted with a different command through busy and the done cycle.
        bus.op = 1'b1; bus.index = 12'd0;
        dc = 0; dcnt = 0;
        for (cyc = 1; cyc < 15; cyc++) begin
            if (bus.done) begin
                dcnt++;
                if (dc == 0) dc = cyc;
                bus.start = 1'b0;
            end
            @(negedge clock);
        end
        bus.start = 1'b0;
        checks++;
        if (dcnt !== 1 || dc !== 6) begin
            errors++; $display("FAIL start_ignored_done: pulses=%0d cyc=%0d want 1 6", dcnt, dc);
        end
        checks++;
        if (heap[300] !== 12'd1 || heap[301] !== 12'd4 || heap[302] !== 12'd2 || heap[303] !== 12'd3
            || bus.error !== 1'b0 || bus.new_length !== 12'd4) begin
            errors++; $display("FAIL start_ignored_result: heap=%0d %0d %0d %0d err=%b nl=%0d want 1 4 2 3 0 4",
                               heap[300], heap[301], heap[302], heap[303], bus.error, bus.new_length);
        end
    endtask

    task automatic test_async_reset();
        int cyc, dc, wc, bc;
        put(12'd400, 12'd1); put(12'd401, 12'd2); put(12'd402, 12'd3);
        @(negedge clock);
        bus.op = 1'b0; bus.base = 12'd400; bus.length = 12'd3; bus.index = 12'd0; bus.value = 12'd9;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.mem_we !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL areset_reach_write: cyc=%0d want 2", cyc); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL areset_drop: busy=%b we=%b done=%b want 0 0 0", bus.busy, bus.mem_we, bus.done);
        end
        @(negedge clock);
        reset = 1'b1;
        put(12'd500, 12'd10); put(12'd501, 12'd20); put(12'd502, 12'd0);
        run_cmd(1'b0, 12'd500, 12'd2, 12'd0, 12'd30, dc, wc, bc);
        checks++;
        if (dc !== 6 || wc !== 3 || bus.new_length !== 12'd3 || bus.error !== 1'b0) begin
            errors++; $display("FAIL areset_recover_status: cyc=%0d writes=%0d nl=%0d err=%b want 6 3 3 0",
                               dc, wc, bus.new_length, bus.error);
        end
        @(negedge clock);
        checks++;
        if (heap[500] !== 12'd30 || heap[501] !== 12'd10 || heap[502] !== 12'd20) begin
            errors++; $display("FAIL areset_recover_heap: got %0d %0d %0d want 30 10 20",
                               heap[500], heap[501], heap[502]);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        bus.start = 1'b0; bus.op = 1'b0; bus.base = '0; bus.length = '0; bus.index = '0; bus.value = '0;
        #12;
        test_reset();
        @(negedge clock);
        reset = 1'b1;
        test_insert();
        test_delete();
        test_insert_end();
        test_delete_last();
        test_errors();
        test_start_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/array_shift_controller.md
# array_shift_controller

Sequencer for the heap array-shift datapath. It implements the insert (shift-up) and delete (shift-down) primitives on one array area held in single-port heap memory, moving one element per read/write pair. It sits between the instruction executor, which issues one command at a time, and the heap memory port, and it owns that port while busy.

## Interface
- MemoryElementWidth, 12: width of a heap element and of value/removed data
- NArea, 10: capacity of one array area in elements
- AddressWidth, 12: heap address width

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- op  in  1  0 = insert at index, 1 = delete at index
- base  in  AddressWidth  heap address of element 0 of the array
- length  in  MemoryElementWidth  current array length
- index  in  MemoryElementWidth  target position
- value  in  MemoryElementWidth  element to insert (op=0)
- mem_addr  out  AddressWidth  heap address
- mem_we  out  1  heap write enable
- mem_wdata  out  MemoryElementWidth  heap write data
- mem_rdata  in  MemoryElementWidth  heap read data, valid the cycle after mem_addr is presented with mem_we=0
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  command rejected; valid with done, held until next start
- new_length  out  MemoryElementWidth  resulting length; valid with done, held
- removed  out  MemoryElementWidth  deleted element (op=1); valid with done, held

## Operation
- States: IDLE, FETCH, TAKE, READ, WRITE, PUT, DONE.
- IDLE + start: latch op/base/length/index/value, check, then:
  - insert legal iff index <= length and length < NArea; i = length; go READ if i > index, else PUT.
  - delete legal iff index < length; go FETCH.
  - illegal: error=1, new_length=length, go DONE; no memory access.
- Insert loop: READ presents base+i-1 (mem_we=0). WRITE drives base+i, mem_we=1, mem_wdata=mem_rdata, i=i-1, then READ if i > index, else PUT. PUT writes value to base+index, then DONE. new_length=length+1.
- Delete: FETCH presents base+index. TAKE captures mem_rdata into removed, i=index, then READ if i < length-1, else DONE. Delete loop: READ presents base+i+1; WRITE drives base+i with mem_rdata, i=i+1, then READ if i < length-1, else DONE. new_length=length-1. Old last slot is not cleared.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^AddressWidth. Index arithmetic uses length/index widths; comparisons are unsigned.
- start while busy is ignored; a start in the DONE cycle is ignored.

## Timing
- Reset (async, reset=0): state IDLE; busy, done, error, mem_we = 0; mem_addr, mem_wdata, new_length, removed = 0. Takes effect immediately.
- Reset mid-operation abandons the command. Heap contents already written stay as they are.
- start accepted at edge 0 → busy=1 from cycle 1 until the done cycle inclusive.
- Working cycles W: insert 2*(length-index)+1; delete 2*(length-1-index)+2; error 0.
- done is high in cycle 1+W.
- mem_we is high only in WRITE and PUT. mem_addr is don't-care in IDLE/DONE.
- Earliest next start: the cycle after done.

## Test plan
- Insert: heap[100..102]={5,6,7}, base=100, length=3, index=1, value=9 → heap[100..103]={5,9,6,7}, new_length=4, error=0, done in cycle 6.
- Delete: heap[100..103]={5,9,6,7}, length=4, index=0 → heap[100..102]={9,6,7}, removed=5, new_length=3, done in cycle 9.
- Boundaries:
  - Insert at end (index=length=2): single PUT, done in cycle 2.
  - Delete last (index=3, length=4): removed=heap[103], no writes, done in cycle 3.
- Errors: insert with length=NArea=10 → error=1, done in cycle 1, new_length=10, no mem_we. Delete with index=length=4 → same rejection.
- Start pulsed during busy and during done → ignored; exactly one done per accepted command.
- reset=0 asynchronously in a WRITE cycle → busy/mem_we drop immediately. After release, a new insert on fresh data completes correctly.
